// File: rtl/keccak_perm_arbiter_if.sv
// Request/response bus between the two sponge front-ends and the shared permutation arbiter.
// The master drives requests and response backpressure; the slave (arbiter) drives readies and responses.
interface keccak_perm_arbiter_if;
  logic          req0_valid;
  logic          req0_ready;
  logic [1599:0] req0_state;
  logic          req1_valid;
  logic          req1_ready;
  logic [1599:0] req1_state;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [1599:0] rsp_state;

  modport master (
    output req0_valid, req0_state, req1_valid, req1_state, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_state
  );

  modport slave (
    input  req0_valid, req0_state, req1_valid, req1_state, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_state
  );
endinterface

// File: rtl/keccak_perm_arbiter.sv
// Round-robin arbiter sharing one iterative Keccak-f[1600] core between two requesters.
// IDLE grants, LOAD pulses core_rst, RUN counts core iterations, RESP holds the result.
module keccak_perm_arbiter #(
  parameter int CORE_CYCLES = 6,
  parameter int CNT_W       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  keccak_perm_arbiter_if.slave bus,
  output logic                 busy,
  output logic                 core_rst,
  output logic [1599:0]        core_ain,
  input  logic [1599:0]        core_aout
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, RESP = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             grant_id, last_grant;
  logic             sel, accept, done;
  logic             ready0, ready1;
  logic [1599:0]    ain_q, rsp_state_q;
  logic             rsp_valid_q, rsp_id_q;

  // On a tie the port that did not win last time is chosen; a lone port always wins.
  always_comb begin
    sel    = bus.req1_valid && (!bus.req0_valid || !last_grant);
    accept = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    done   = (state == RUN) && (cnt == CNT_W'(CORE_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready0    = 1'b0;
    ready1    = 1'b0;
    case (state)
      IDLE: begin
        ready0 = accept && !sel;
        ready1 = accept && sel;
        if (accept) state_nxt = LOAD;
      end
      LOAD:    state_nxt = RUN;
      RUN:     if (done) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ain_q       <= '0;
      cnt         <= '0;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_state_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ain_q      <= sel ? bus.req1_state : bus.req0_state;
          grant_id   <= sel;
          last_grant <= sel;
        end
        LOAD: cnt <= CNT_W'(1);
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (done) begin
            rsp_state_q <= core_aout;
            rsp_id_q    <= grant_id;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_state  = rsp_state_q;
  assign busy           = (state != IDLE);
  assign core_rst       = (state == LOAD);
  assign core_ain       = ain_q;
endmodule

// File: doc/keccak_perm_arbiter.md
Name: keccak_perm_arbiter

Overview:
- Shares one iterative Keccak-f[1600] permutation core between two requesters: port 0 (SHAKE128 matrix expansion) and port 1 (SHAKE256 sampling/hashing).
- Accepts a 1600-bit state from the granted requester and loads it into the core.
- Sequences the core's fixed iteration count and returns the permuted state with a requester ID.
- Sits between the sponge front-ends and the permutation core; it is the only driver of the core's inputs.

Parameters:
- CORE_CYCLES, 6, cycles after the core load cycle until core_aout holds the final 24-round result (6 iterations of 4 rounds).
- CNT_W, 3, width of the iteration counter; must satisfy 2^CNT_W > CORE_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has a state to permute
- req0_ready  out  1  arbiter accepts requester 0 this cycle
- req0_state  in  1600  requester 0 input state
- req1_valid  in  1  requester 1 has a state to permute
- req1_ready  out  1  arbiter accepts requester 1 this cycle
- req1_state  in  1600  requester 1 input state
- rsp_valid  out  1  permuted state available
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that owns the response (0/1)
- rsp_state  out  1600  permuted state
- busy  out  1  high in any state other than IDLE
- core_rst  out  1  drives the core's rst: load core_ain, clear core round counter
- core_ain  out  1600  drives the core's Ain
- core_aout  in  1600  core's Aout

Behaviour:
- Reset (rst=1 at an edge): state goes to IDLE; rsp_valid, rsp_id, rsp_state, core_ain register and counter all go to 0; last_grant goes to 1, so requester 0 wins the first tie. Reset has priority over everything.
- Reset mid-operation: any in-flight permutation is dropped silently; no response is produced.
- IDLE:
  - req0_ready and req1_ready are combinational and may be high only in IDLE.
  - Only one ready is high at a time; it goes to the selected requester.
  - Selection: a single valid requester is granted. If both are valid, the requester not equal to last_grant is granted (round-robin).
  - When valid&&ready at an edge: capture that requester's state into the core_ain register, set grant_id and last_grant, and go to LOAD.
- LOAD (1 cycle): core_rst=1 and core_ain=captured state. Counter is set to 1 at the edge, then go to RUN.
- RUN:
  - core_rst=0 and core_ain is held stable. The counter increments each cycle.
  - When counter==CORE_CYCLES, at the edge: rsp_state<=core_aout, rsp_id<=grant_id, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_state are held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid<=0 and go to IDLE.
  - No new request is accepted in the same cycle.
- core_rst is 0 in every state except LOAD.
- Latency: accept edge in cycle A, LOAD in cycle A+1, RUN in cycles A+2 to A+7, rsp_valid high from cycle A+8 (for CORE_CYCLES=6).
- Throughput: minimum request-to-request spacing is CORE_CYCLES+3 cycles.
- Requesters are stalled (ready=0) throughout LOAD, RUN and RESP. Their valid and state must be held until accepted.
- A valid request that drops before acceptance is not checked. The arbiter simply re-evaluates each IDLE cycle.
- busy = (state != IDLE).
- last_grant changes only on acceptance. Requests from one port alone never block on fairness.

Test Plan:
- Single request: rst for 2 cycles, then req0_valid=1 with state all-zero, rsp_ready=1. Required: req0_ready high in the first IDLE cycle; core_rst high exactly 1 cycle; rsp_valid high 8 cycles after acceptance; rsp_id=0; lane[0] (bits 63:0) of rsp_state = 0xF1258F7940E1DDE7; back in IDLE next cycle.
- Simultaneous requests: req0 and req1 both valid continuously, with distinct states. Required: grant order 0,1,0,1; rsp_id sequence 0,1,0,1; each rsp_state matches a software Keccak-f of its own input.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid rises. Required: rsp_state and rsp_id stable; busy=1; req*_ready=0 throughout. Completion occurs on the cycle rsp_ready=1.
- Reset mid-RUN: assert rst in the 3rd RUN cycle. Required: next cycle is IDLE; rsp_valid=0; no response ever appears for that request. A fresh req1 request then completes normally with rsp_id=1.
- Single-port streaming: only req1_valid asserted for 3 requests. Required: all 3 are granted; spacing between acceptances is exactly 9 cycles with rsp_ready tied high; last_grant does not block.
